game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/mm_pkg.sv | 18 +
 rtl/turn_thermo.sv | 18 +
 rtl/game_sequencer.sv | 158 +++++++++++++++
 tb/tb_game_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the Mastermind game slice: sequencer states and sizing constants.
package mm_pkg;

    localparam int COLOR_W       = 3;
    localparam int DEF_MAX_TURNS = 8;
    localparam int PEGS          = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        GUESS,
        SUBMIT,
        SCORE_WAIT,
        WIN,
        LOSE
    } state_t;

endpackage

// File: rtl/turn_thermo.sv
// Remaining-turn thermometer for the switch LEDs: bit i is lit while i < MAX_TURNS - turn.
module turn_thermo
    import mm_pkg::*;
#(
    parameter int MAX_TURNS = DEF_MAX_TURNS
) (
    input  logic [2:0] turn,
    output logic [7:0] sw_led
);

    always_comb begin
        sw_led = '0;
        for (int i = 0; i < 8; i++) begin
            sw_led[i] = (i < (MAX_TURNS - int'(turn)));
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Mastermind game sequencer: latches the secret code, counts turns and handshakes with the scorer.
// Optional duplicate-guess rejection (with dup_flag output) is built when MM_DUP_GUESS_REJECT_EN is defined.
module game_sequencer
    import mm_pkg::*;
#(
    parameter int MAX_TURNS = DEF_MAX_TURNS,
    parameter int COLOR_W   = mm_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               select,
    input  logic [COLOR_W-1:0] guess0,
    input  logic [COLOR_W-1:0] guess1,
    input  logic [COLOR_W-1:0] guess2,
    input  logic [COLOR_W-1:0] guess3,
    input  logic [COLOR_W-1:0] prng0,
    input  logic [COLOR_W-1:0] prng1,
    input  logic [COLOR_W-1:0] prng2,
    input  logic [COLOR_W-1:0] prng3,
    output logic [COLOR_W-1:0] code0,
    output logic [COLOR_W-1:0] code1,
    output logic [COLOR_W-1:0] code2,
    output logic [COLOR_W-1:0] code3,
    output logic               hist_we,
    output logic [2:0]         hist_addr,
    output logic               score_req,
    input  logic               score_ack,
    input  logic [2:0]         score_black,
    output logic [2:0]         turn,
    output logic [7:0]         sw_led,
`ifdef MM_DUP_GUESS_REJECT_EN
    output logic               dup_flag,
`endif
    output logic               won,
    output logic               lost,
    output logic               game_over
);

    state_t state_q, state_d;
    logic   rst_meta, rst_sync_n;
    logic   ack_win, at_last_turn, dup_reject;

    // Reset asserts asynchronously but releases two edges later, so state never moves on a ragged release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    assign ack_win      = (score_black == 3'd4);
    assign at_last_turn = (turn == 3'(MAX_TURNS - 1));

`ifdef MM_DUP_GUESS_REJECT_EN
    logic [PEGS*COLOR_W-1:0] guess_vec, last_guess;

    assign guess_vec  = {guess3, guess2, guess1, guess0};
    assign dup_reject = (turn != 3'd0) && (guess_vec == last_guess);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            last_guess <= '0;
            dup_flag   <= 1'b0;
        end else begin
            dup_flag <= (state_q == GUESS) && select && !start && dup_reject;
            if (state_q == ARM) begin
                last_guess <= '0;
            end else if ((state_q == GUESS) && select && !start && !dup_reject) begin
                last_guess <= guess_vec;
            end
        end
    end
`else
    logic unused_guess;

    assign unused_guess = ^{guess3, guess2, guess1, guess0};
    assign dup_reject   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start pulse aborts any game in progress; start always wins over select or ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) state_d = ARM;
            end
            ARM: begin
                state_d = GUESS;
            end
            GUESS: begin
                if (start)                    state_d = ARM;
                else if (select && !dup_reject) state_d = SUBMIT;
            end
            SUBMIT: begin
                if (start) state_d = ARM;
                else       state_d = SCORE_WAIT;
            end
            SCORE_WAIT: begin
                if (start) begin
                    state_d = ARM;
                end else if (score_ack) begin
                    if (ack_win)           state_d = WIN;
                    else if (at_last_turn) state_d = LOSE;
                    else                   state_d = GUESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Turn only advances on a non-winning ack that returns to GUESS, so it can never pass MAX_TURNS-1.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            turn  <= '0;
            code0 <= '0;
            code1 <= '0;
            code2 <= '0;
            code3 <= '0;
        end else if (state_q == ARM) begin
            turn  <= '0;
            code0 <= prng0;
            code1 <= prng1;
            code2 <= prng2;
            code3 <= prng3;
        end else if ((state_q == SCORE_WAIT) && (state_d == GUESS)) begin
            turn <= turn + 3'd1;
        end
    end

    assign hist_we   = (state_q == SUBMIT);
    assign hist_addr = turn;
    assign score_req = (state_q == SCORE_WAIT);
    assign won       = (state_q == WIN);
    assign lost      = (state_q == LOSE);
    assign game_over = won | lost;

    turn_thermo #(
        .MAX_TURNS (MAX_TURNS)
    ) u_thermo (
        .turn   (turn),
        .sw_led (sw_led)
    );

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: vector table, hand-written corner sequences and randomized games.
module tb_game_sequencer;

    localparam int MT = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, select, score_ack;
    logic [2:0] score_black;
    logic [2:0] guess0, guess1, guess2, guess3;
    logic [2:0] prng0, prng1, prng2, prng3;
    logic [2:0] code0, code1, code2, code3;
    logic       hist_we, score_req, won, lost, game_over;
    logic [2:0] hist_addr, turn;
    logic [7:0] sw_led;
`ifdef MM_DUP_GUESS_REJECT_EN
    logic       dup_flag;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       select;
        logic       ack;
        logic [2:0] black;
        logic       we;
        logic       req;
        logic [2:0] turn;
        logic       won;
        logic       lost;
    } vec_t;

    vec_t vecs[$];

    game_sequencer #(.MAX_TURNS(MT), .COLOR_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .select      (select),
        .guess0      (guess0),
        .guess1      (guess1),
        .guess2      (guess2),
        .guess3      (guess3),
        .prng0       (prng0),
        .prng1       (prng1),
        .prng2       (prng2),
        .prng3       (prng3),
        .code0       (code0),
        .code1       (code1),
        .code2       (code2),
        .code3       (code3),
        .hist_we     (hist_we),
        .hist_addr   (hist_addr),
        .score_req   (score_req),
        .score_ack   (score_ack),
        .score_black (score_black),
        .turn        (turn),
        .sw_led      (sw_led),
`ifdef MM_DUP_GUESS_REJECT_EN
        .dup_flag    (dup_flag),
`endif
        .won         (won),
        .lost        (lost),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic s, input logic sel, input logic ack, input int blk,
                                input logic we, input logic req, input int trn,
                                input logic wn, input logic ls);
        vec_t v;
        v.start = s; v.select = sel; v.ack = ack; v.black = 3'(blk);
        v.we = we; v.req = req; v.turn = 3'(trn); v.won = wn; v.lost = ls;
        return v;
    endfunction

    function automatic int thermo(input int t);
        return (1 << (MT - t)) - 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sel, input logic ack, input logic [2:0] blk);
        start       = s;
        select      = sel;
        score_ack   = ack;
        score_black = blk;
        tick();
        start     = 1'b0;
        select    = 1'b0;
        score_ack = 1'b0;
    endtask

    task automatic setGuess(input logic [11:0] g);
        {guess3, guess2, guess1, guess0} = g;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        logic [11:0] code_exp, g, last_sub;
        logic [2:0]  blk;
        int          m_turn, n;
        bit          done;

        reset_n = 1'b0;
        start = 0; select = 0; score_ack = 0; score_black = 0;
        setGuess(12'h000);
        {prng3, prng2, prng1, prng0} = 12'h5A3;

        // Values held while reset is asserted
        #2;
        checkOutput("rst_sw_led", sw_led, 8'hFF);
        checkOutput("rst_code", {code3, code2, code1, code0}, 0);
        checkOutput("rst_turn", turn, 0);
        checkOutput("rst_req", score_req, 0);
        checkOutput("rst_we", hist_we, 0);
        checkOutput("rst_status", {won, lost, game_over}, 0);

        // A start held across the first two edges after release must be ignored
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start   = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("sync_release_code", {code3, code2, code1, code0}, 0);
        checkOutput("sync_release_req", score_req, 0);

        // Vector table: win on the third SCORE_WAIT cycle, ignored inputs, start priority
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4, 0, 0, 0, 1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].start, vecs[i].select, vecs[i].ack, vecs[i].black);
            checkOutput($sformatf("vec%0d_we", i), hist_we, vecs[i].we);
            checkOutput($sformatf("vec%0d_req", i), score_req, vecs[i].req);
            checkOutput($sformatf("vec%0d_turn", i), turn, vecs[i].turn);
            checkOutput($sformatf("vec%0d_won", i), won, vecs[i].won);
            checkOutput($sformatf("vec%0d_lost", i), lost, vecs[i].lost);
            checkOutput($sformatf("vec%0d_over", i), game_over, vecs[i].won | vecs[i].lost);
            if (vecs[i].we) checkOutput($sformatf("vec%0d_addr", i), hist_addr, vecs[i].turn);
        end

        // Eight losing submissions walk hist_addr and the LED thermometer down
        applyStimulus(1, 0, 0, 0);
        tick();
        for (int t = 0; t < MT; t++) begin
            checkOutput($sformatf("loss_led%0d", t), sw_led, thermo(t));
            setGuess(12'(t + 1));
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("loss_we%0d", t), hist_we, 1);
            checkOutput($sformatf("loss_addr%0d", t), hist_addr, t);
            tick();
            checkOutput($sformatf("loss_req%0d", t), score_req, 1);
            applyStimulus(0, 0, 1, 3'd2);
            checkOutput($sformatf("loss_lost%0d", t), lost, (t == MT - 1) ? 1 : 0);
            checkOutput($sformatf("loss_turn%0d", t), turn, (t == MT - 1) ? t : t + 1);
        end
        checkOutput("loss_led_final", sw_led, 8'h01);
        applyStimulus(0, 1, 1, 3'd4);
        checkOutput("lose_sel_lost", lost, 1);
        checkOutput("lose_sel_we", hist_we, 0);
        checkOutput("lose_sel_won", won, 0);
        checkOutput("lose_sel_turn", turn, MT - 1);

        // Abort from SCORE_WAIT relatches the code
        {prng3, prng2, prng1, prng0} = 12'h1C7;
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("abort_code_a", {code3, code2, code1, code0}, 12'h1C7);
        setGuess(12'h111);
        applyStimulus(0, 1, 0, 0);
        tick();
        checkOutput("abort_req_before", score_req, 1);
        {prng3, prng2, prng1, prng0} = 12'hE52;
        applyStimulus(1, 0, 1, 3'd4);
        checkOutput("abort_req_after", score_req, 0);
        checkOutput("abort_won", won, 0);
        tick();
        checkOutput("abort_code_b", {code3, code2, code1, code0}, 12'hE52);
        checkOutput("abort_turn", turn, 0);

        // Reset pulled mid-SCORE_WAIT drops score_req without a clock edge
        applyStimulus(0, 1, 0, 0);
        tick();
        checkOutput("arst_req_before", score_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_req", score_req, 0);
        checkOutput("arst_code", {code3, code2, code1, code0}, 0);
        checkOutput("arst_turn", turn, 0);
        releaseReset();
        applyStimulus(0, 1, 0, 0);
        checkOutput("arst_idle_we", hist_we, 0);
        tick();
        checkOutput("arst_idle_req", score_req, 0);

`ifdef MM_DUP_GUESS_REJECT_EN
        // Re-submitting the same guess is rejected with a one-cycle dup_flag
        applyStimulus(1, 0, 0, 0);
        tick();
        setGuess(12'h2A5);
        applyStimulus(0, 1, 0, 0);
        checkOutput("dup_first_we", hist_we, 1);
        tick();
        applyStimulus(0, 0, 1, 3'd0);
        checkOutput("dup_turn1", turn, 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("dup_we", hist_we, 0);
        checkOutput("dup_flag", dup_flag, 1);
        checkOutput("dup_turn", turn, 1);
        tick();
        checkOutput("dup_flag_clear", dup_flag, 0);
        checkOutput("dup_req", score_req, 0);
        setGuess(12'h2A6);
        applyStimulus(0, 1, 0, 0);
        checkOutput("dup_new_we", hist_we, 1);
        checkOutput("dup_new_addr", hist_addr, 1);
        tick();
        applyStimulus(0, 0, 1, 3'd4);
        checkOutput("dup_win", won, 1);
`endif

        // Randomized games against a turn-counting model of the rules
        for (int gm = 0; gm < 25; gm++) begin
            code_exp = 12'($urandom);
            {prng3, prng2, prng1, prng0} = code_exp;
            applyStimulus(1, 0, 0, 0);
            tick();
            checkOutput($sformatf("rnd%0d_code", gm), {code3, code2, code1, code0}, code_exp);
            m_turn   = 0;
            done     = 0;
            last_sub = 12'hFFF;
            while (!done) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    applyStimulus(0, 0, 1, 3'd4);
                    checkOutput("rnd_spur_req", score_req, 0);
                    checkOutput("rnd_spur_turn", turn, m_turn);
                    checkOutput("rnd_spur_won", won, 0);
                end
                g = 12'($urandom);
                if (g == last_sub) g[0] = ~g[0];
                last_sub = g;
                setGuess(g);
                applyStimulus(0, 1, 0, 0);
                checkOutput("rnd_we", hist_we, 1);
                checkOutput("rnd_addr", hist_addr, m_turn);
                tick();
                checkOutput("rnd_req", score_req, 1);
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    tick();
                    checkOutput("rnd_req_hold", score_req, 1);
                end
                if ($urandom_range(0, 9) == 0) blk = 3'd4;
                else begin
                    blk = 3'($urandom_range(0, 6));
                    if (blk >= 3'd4) blk = blk + 3'd1;
                end
                applyStimulus(0, 0, 1, blk);
                if (blk == 3'd4) begin
                    done = 1;
                    checkOutput("rnd_won", won, 1);
                    checkOutput("rnd_lost", lost, 0);
                end else if (m_turn == MT - 1) begin
                    done = 1;
                    checkOutput("rnd_won", won, 0);
                    checkOutput("rnd_lost", lost, 1);
                end else begin
                    m_turn++;
                    checkOutput("rnd_status", {won, lost}, 0);
                end
                checkOutput("rnd_over", game_over, done);
                checkOutput("rnd_req_drop", score_req, 0);
                checkOutput("rnd_turn", turn, m_turn);
                checkOutput("rnd_led", sw_led, thermo(m_turn));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
